dac_sample_feeder: RTL and testbench
====================================

DAC_SAMPLE_FEEDER -- requirements
Module: dac_sample_feeder

Interface
REQ-001 Parameter WORD_WIDTH, default 16, sample width in bits; SHALL equal the WORD_WIDTH of the downstream SPI main.
REQ-002 Parameter FIFO_DEPTH, default 4, sample buffer entries; SHALL be a power of two, >= 2.
REQ-003 Parameter DIV_WIDTH, default 8, width of the update-period register.
REQ-004 sys_clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  1 = periodic DAC updates run; 0 = timer held, no loads issued.
REQ-007 rate_div  in  DIV_WIDTH  update period in sys_clk cycles; sampled on every timer reload.
REQ-008 sample_in  in  WORD_WIDTH  sample from the DDS datapath.
REQ-009 sample_valid  in  1  sample_in is valid.
REQ-010 sample_ready  out  1  FIFO can accept; transfer when valid && ready.
REQ-011 power_state_req  in  2  requested DAC8411 power-down mode.
REQ-012 spi_csb  in  1  chip select from SPI main; 1 = idle.
REQ-013 load  out  1  one-cycle pulse to SPI main.
REQ-014 parallel_in  out  WORD_WIDTH  word to shift; stable while load = 1.
REQ-015 power_state  out  2  power bits accompanying parallel_in.
REQ-016 fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently buffered.
REQ-017 underrun  out  1  sticky: update tick with empty FIFO.
REQ-018 overrun  out  1  sticky: update tick while SPI busy.

Function
REQ-019 Timer SHALL count down from max(rate_div,19)-1 to 0 while enable = 1, generating one-cycle tick at 0, then reload; values below 19 SHALL clamp to 19 (18-bit frame + 1 idle cycle).
REQ-020 enable = 0 SHALL reload the timer and suppress tick; rising enable SHALL produce the first tick after a full period.
REQ-021 On tick with spi_csb = 1 and FIFO non-empty: pop head, drive it on parallel_in, assert load for exactly that tick cycle; latency tick-to-load 0 cycles (registered outputs update on the tick edge).
REQ-022 On tick with spi_csb = 1 and FIFO empty: re-send the last transmitted sample (0 after reset) with load, set underrun.
REQ-023 On tick with spi_csb = 0: no load, no pop, set overrun.
REQ-024 power_state SHALL capture power_state_req only at load; a change between ticks takes effect on the next load.
REQ-025 load SHALL never assert on two consecutive cycles.
REQ-026 FIFO: push on sample_valid && sample_ready; sample_ready = (fifo_level < FIFO_DEPTH); simultaneous push and pop when full or empty-with-push SHALL both occur in the same cycle, level unchanged when full; empty-with-push still counts as empty for that tick's pop (pushed sample not forwarded same cycle).
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL be exact at all times.
REQ-028 underrun and overrun SHALL clear only on reset.

Reset
REQ-029 On rst: FIFO emptied (fifo_level = 0), timer reloaded, load = 0, parallel_in = 0, power_state = 0, underrun = 0, overrun = 0, last sample = 0.
REQ-030 rst asserted mid-frame SHALL clear state immediately; the SPI main is not reset by this block, so the first post-reset load SHALL still respect spi_csb.
REQ-031 sample_ready SHALL be 0 during rst and 1 the first cycle after release.

Structure
REQ-032 Shared header: frame length constant (18), minimum period (19), power-state encodings (00 normal, 01 1k, 10 100k, 11 hi-Z).
REQ-033 FIFO SHALL be a sub-module, sample_fifo (WORD_WIDTH, FIFO_DEPTH parameters, push/pop/level interface); timer and load control in the top.

Verification
REQ-034 rate_div = 32, push 0x1234, 0xABCD: loads exactly 32 cycles apart carrying 0x1234 then 0xABCD, fifo_level 2 -> 0, no flags.
REQ-035 rate_div = 32, FIFO empty at a tick after sending 0x0F0F: load with 0x0F0F, underrun = 1.
REQ-036 rate_div = 5: observed period 19 cycles; with SPI model, overrun stays 0.
REQ-037 Force spi_csb = 0 across a tick: no load, FIFO level unchanged, overrun = 1.
REQ-038 Fill 4 entries, hold valid: sample_ready = 0; at tick, pop and push same cycle, level stays 4.
REQ-039 power_state_req 00 -> 11 mid-period, then rst during SPI frame: next load carries 11; after rst all outputs 0, first load waits for spi_csb = 1.

Source files
------------

// File: rtl/dac_sample_feeder_pkg.sv
// Shared constants for the DAC8411 sample feeder: SPI frame timing and
// the power-down encodings carried alongside each sample.
package dac_sample_feeder_pkg;

    // One DAC8411 frame is 2 power bits + 16 data bits.
    localparam int FRAME_LEN  = 18;
    // A frame plus one idle cycle with chip select high.
    localparam int MIN_PERIOD = FRAME_LEN + 1;

    // DAC8411 power-down modes (PD1:PD0).
    localparam logic [1:0] PWR_NORMAL = 2'b00;
    localparam logic [1:0] PWR_1K     = 2'b01;
    localparam logic [1:0] PWR_100K   = 2'b10;
    localparam logic [1:0] PWR_HIZ    = 2'b11;

endpackage

// File: rtl/sample_fifo.sv
// Small sample buffer between the DDS datapath and the DAC update timer.
// A push against a full buffer is still taken when a pop happens in the
// same cycle, so a producer holding valid is not stalled for an extra
// update period.
module sample_fifo
    import dac_sample_feeder_pkg::*;
#(
    parameter  int WORD_WIDTH = 16,
    parameter  int FIFO_DEPTH = 4,
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int LVL_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WORD_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [WORD_WIDTH-1:0] head,
    output logic [LVL_W-1:0]      level,
    output logic                  full,
    output logic                  empty
);

    logic [FIFO_DEPTH-1:0][WORD_WIDTH-1:0] mem;
    logic [PTR_W-1:0]                      wr_ptr;
    logic [PTR_W-1:0]                      rd_ptr;
    logic                                  do_push;
    logic                                  do_pop;

    assign full    = (level == LVL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    // An empty buffer never pops, even if a push lands in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since level guards every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); level tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_sample_feeder.sv
// Paces buffered DDS samples into a DAC8411 SPI main: a programmable
// update timer issues one load per period, re-sending the previous word
// when the buffer runs dry and skipping the update if the SPI main is
// still mid-frame. Requires DIV_WIDTH >= 5 so the minimum period fits.
module dac_sample_feeder
    import dac_sample_feeder_pkg::*;
#(
    parameter  int WORD_WIDTH = 16,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DIV_WIDTH  = 8,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    input  logic [WORD_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [1:0]            power_state_req,
    input  logic                  spi_csb,
    output logic                  load,
    output logic [WORD_WIDTH-1:0] parallel_in,
    output logic [1:0]            power_state,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  underrun,
    output logic                  overrun
);

    localparam logic [DIV_WIDTH-1:0] MIN_RELOAD = DIV_WIDTH'(MIN_PERIOD - 1);

    logic [DIV_WIDTH-1:0]  tmr_cnt;
    logic [DIV_WIDTH-1:0]  reload_val;
    logic                  tmr_armed;
    logic                  tick;
    logic                  fire;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [WORD_WIDTH-1:0] fifo_head;

    // Clamp the requested period so a full frame plus an idle cycle fits.
    always_comb begin
        reload_val = MIN_RELOAD;
        if (rate_div > MIN_RELOAD) begin
            reload_val = rate_div - 1'b1;
        end
    end

    // Down-counter; while disabled (or just out of reset) it keeps
    // reloading, so the first tick after enable rises is a full period out.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tmr_cnt   <= MIN_RELOAD;
            tmr_armed <= 1'b0;
        end else if (!enable || !tmr_armed) begin
            tmr_cnt   <= reload_val;
            tmr_armed <= enable;
        end else if (tmr_cnt == '0) begin
            tmr_cnt   <= reload_val;
        end else begin
            tmr_cnt   <= tmr_cnt - 1'b1;
        end
    end

    assign tick = enable && tmr_armed && (tmr_cnt == '0);
    // Update only when the SPI main is idle; the !load term keeps loads
    // non-adjacent regardless of the period.
    assign fire = tick && spi_csb && !load;

    // Held low through reset so nothing is offered while state is cleared.
    assign sample_ready = !rst && !fifo_full;

    sample_fifo #(
        .WORD_WIDTH (WORD_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sys_clk),
        .rst       (rst),
        .push      (sample_valid),
        .push_data (sample_in),
        .pop       (fire),
        .head      (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Load generation. parallel_in only changes on a load, so it doubles
    // as the last-sent sample that an underrun repeats.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            load        <= 1'b0;
            parallel_in <= '0;
            power_state <= PWR_NORMAL;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            load <= 1'b0;
            if (fire) begin
                load        <= 1'b1;
                power_state <= power_state_req;
                if (fifo_empty) begin
                    underrun <= 1'b1;
                end else begin
                    parallel_in <= fifo_head;
                end
            end else if (tick && !spi_csb) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench for dac_sample_feeder: expected (data, power) pairs are
// queued as stimulus is driven and popped by a load monitor. A simple SPI
// main model holds chip select low for one frame starting with the load.
module tb_dac_sample_feeder;
    import dac_sample_feeder_pkg::*;

    localparam int WW = 16;
    localparam int FD = 4;
    localparam int DW = 8;
    localparam int LW = $clog2(FD) + 1;

    typedef struct {
        logic [WW-1:0] d;
        logic [1:0]    p;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] rate_div;
    logic [WW-1:0] sample_in;
    logic          sample_valid;
    logic          sample_ready;
    logic [1:0]    power_state_req;
    logic          spi_csb;
    logic          load;
    logic [WW-1:0] parallel_in;
    logic [1:0]    power_state;
    logic [LW-1:0] fifo_level;
    logic          underrun;
    logic          overrun;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   load_cnt = 0;
    int   last_load_cyc = 0;
    int   prev_load_cyc = 0;
    logic load_d = 1'b0;
    logic force_busy = 1'b0;
    int   busy_cnt = 0;
    bit   ok;

    always #5 sys_clk = ~sys_clk;

    dac_sample_feeder #(
        .WORD_WIDTH (WW),
        .FIFO_DEPTH (FD),
        .DIV_WIDTH  (DW)
    ) dut (
        .sys_clk         (sys_clk),
        .rst             (rst),
        .enable          (enable),
        .rate_div        (rate_div),
        .sample_in       (sample_in),
        .sample_valid    (sample_valid),
        .sample_ready    (sample_ready),
        .power_state_req (power_state_req),
        .spi_csb         (spi_csb),
        .load            (load),
        .parallel_in     (parallel_in),
        .power_state     (power_state),
        .fifo_level      (fifo_level),
        .underrun        (underrun),
        .overrun         (overrun)
    );

    // SPI main: frame occupies the load cycle plus FRAME_LEN-1 more cycles.
    always @(posedge sys_clk) begin
        if (load) busy_cnt <= FRAME_LEN - 1;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign spi_csb = ~(force_busy | load | (busy_cnt != 0));

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Load monitor: compares every load against the scoreboard head.
    always @(posedge sys_clk) begin
        exp_t e;
        #1;
        if (load) begin
            chk("load_gap", load_d, 1'b0);
            if (exp_q.size() == 0) begin
                chk("exp_q_size", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("load_data", parallel_in, e.d);
                chk("load_pwr", power_state, e.p);
            end
            prev_load_cyc = last_load_cyc;
            last_load_cyc = cyc;
            load_cnt++;
        end
        load_d = load;
    end

    task automatic exp_push(input logic [WW-1:0] d, input logic [1:0] p);
        exp_t e;
        e.d = d;
        e.p = p;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [WW-1:0] d, input logic [1:0] p);
        bit acc;
        acc = 1'b0;
        sample_in    = d;
        sample_valid = 1'b1;
        for (int i = 0; i < 64 && !acc; i++) begin
            if (sample_ready) acc = 1'b1;
            @(negedge sys_clk);
        end
        sample_valid = 1'b0;
        chk("push_acc", acc, 1'b1);
        if (acc) exp_push(d, p);
    endtask

    task automatic wait_load(input int budget, output bit got);
        int start;
        start = load_cnt;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge sys_clk);
            if (load_cnt != start) got = 1'b1;
        end
    endtask

    task automatic load_ok(input string tag, input int budget);
        bit got;
        wait_load(budget, got);
        chk(tag, got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; rate_div = 8'd32;
        sample_in = '0; sample_valid = 1'b0; power_state_req = PWR_NORMAL;

        // Reset state
        repeat (3) @(negedge sys_clk);
        chk("rst_ready", sample_ready, 1'b0);
        chk("rst_level", fifo_level, 0);
        chk("rst_load", load, 1'b0);
        chk("rst_pin", parallel_in, 0);
        chk("rst_pwr", power_state, 0);
        chk("rst_flags", {underrun, overrun}, 0);
        rst = 1'b0;
        @(negedge sys_clk);
        chk("ready_post_rst", sample_ready, 1'b1);

        // Two samples, 32-cycle period
        push(16'h1234, PWR_NORMAL);
        push(16'hABCD, PWR_NORMAL);
        chk("lvl_2", fifo_level, 2);
        enable = 1'b1;
        load_ok("load_1", 100);
        chk("lvl_1", fifo_level, 1);
        load_ok("load_2", 40);
        chk("period_32", last_load_cyc - prev_load_cyc, 32);
        chk("lvl_0", fifo_level, 0);
        chk("flags_clean", {underrun, overrun}, 0);

        // Underrun repeats the last sent word
        push(16'h0F0F, PWR_NORMAL);
        load_ok("load_3", 40);
        chk("underrun_pre", underrun, 1'b0);
        exp_push(16'h0F0F, PWR_NORMAL);
        load_ok("load_4", 40);
        chk("period_u", last_load_cyc - prev_load_cyc, 32);
        chk("underrun", underrun, 1'b1);

        // Period below minimum clamps to 19; takes effect at next reload
        rate_div = 8'd5;
        repeat (3) exp_push(16'h0F0F, PWR_NORMAL);
        load_ok("load_5", 40);
        chk("period_old", last_load_cyc - prev_load_cyc, 32);
        load_ok("load_6", 30);
        chk("period_19a", last_load_cyc - prev_load_cyc, 19);
        load_ok("load_7", 30);
        chk("period_19b", last_load_cyc - prev_load_cyc, 19);
        chk("overrun_clean", overrun, 1'b0);

        // SPI busy across a tick: no load, no pop, overrun
        force_busy = 1'b1;
        push(16'h5555, PWR_NORMAL);
        wait_load(25, ok);
        chk("busy_no_load", ok, 1'b0);
        chk("busy_lvl", fifo_level, 1);
        chk("overrun", overrun, 1'b1);
        force_busy = 1'b0;
        load_ok("load_8", 25);

        // Full buffer with valid held: pop and push in the tick cycle
        push(16'hA000, PWR_NORMAL);
        push(16'hA001, PWR_NORMAL);
        push(16'hA002, PWR_NORMAL);
        push(16'hA003, PWR_NORMAL);
        chk("full_lvl", fifo_level, 4);
        chk("full_ready", sample_ready, 1'b0);
        sample_in = 16'hA004;
        sample_valid = 1'b1;
        load_ok("load_9", 25);
        sample_valid = 1'b0;
        exp_push(16'hA004, PWR_NORMAL);
        chk("full_swap_lvl", fifo_level, 4);
        for (int i = 0; i < 4; i++) load_ok("drain", 25);
        chk("drained_lvl", fifo_level, 0);

        // Power mode change mid-period, then reset during a frame
        repeat (5) @(negedge sys_clk);
        power_state_req = PWR_HIZ;
        push(16'h3C3C, PWR_HIZ);
        load_ok("load_pwr", 25);
        repeat (3) @(negedge sys_clk);
        rst = 1'b1;
        @(negedge sys_clk);
        chk("rst2_ready", sample_ready, 1'b0);
        chk("rst2_load", load, 1'b0);
        chk("rst2_pin", parallel_in, 0);
        chk("rst2_pwr", power_state, 0);
        chk("rst2_lvl", fifo_level, 0);
        chk("rst2_flags", {underrun, overrun}, 0);
        rst = 1'b0;
        force_busy = 1'b1;
        wait_load(25, ok);
        chk("post_rst_wait", ok, 1'b0);
        chk("post_rst_ovr", overrun, 1'b1);
        chk("post_rst_und", underrun, 1'b0);
        force_busy = 1'b0;
        exp_push(16'h0000, PWR_HIZ);
        load_ok("load_post_rst", 25);
        chk("post_rst_und2", underrun, 1'b1);
        chk("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
